// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if
//   Request/response bundle for the sequential Booth multiplier.
//
//   Handshake: a request is accepted on a rising edge where start_i=1,
//   flush_i=0 and busy_o=0. The operands, signedness flags and high_i are
//   sampled only on that edge. busy_o stays high while the operation runs.
//   done_o is a one-cycle pulse in the cycle after the last iteration, and
//   product_o carries the result from that cycle on. flush_i kills any
//   in-flight operation without a done_o pulse. start_i is not queued.
//
//   master : execute-stage side (drives requests, observes results)
//   slave  : multiplier side
interface booth_mul_seq_if #(
   parameter int WIDTH = 64
);
   logic             start_i;
   logic             flush_i;
   logic [WIDTH-1:0] multiplicand_i;
   logic [WIDTH-1:0] multiplier_i;
   logic             signed_a_i;
   logic             signed_b_i;
   logic             high_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] product_o;

   modport master (
      output start_i, flush_i, multiplicand_i, multiplier_i,
             signed_a_i, signed_b_i, high_i,
      input  busy_o, done_o, product_o
   );

   modport slave (
      input  start_i, flush_i, multiplicand_i, multiplier_i,
             signed_a_i, signed_b_i, high_i,
      output busy_o, done_o, product_o
   );
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq
//   Multi-cycle radix-4 Booth multiplier for the execute-stage multiply unit.
//   Each operand is independently signed or unsigned (MUL/MULH/MULHSU/MULHU).
//   high_i selects the upper or lower WIDTH bits of the 2*WIDTH product.
//   One Booth digit is retired per cycle, so an operation takes
//   N = WIDTH/2 + 1 RUN cycles, and done_o follows one cycle later.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset_i    : synchronous active-high reset (aborts like a flush and
//                also clears product_o)
//   bus        : booth_mul_seq_if.slave request/response bundle
//   dbg_state  : current FSM state (0 = IDLE, 1 = RUN)
module booth_mul_seq #(
   parameter int WIDTH = 64
) (
   input  logic            clk,
   input  logic            reset_i,
   booth_mul_seq_if.slave  bus,
   output logic            dbg_state
);

   localparam int N  = WIDTH / 2 + 1;      // Booth digits / RUN cycles
   localparam int EW = WIDTH + 2;          // extended operand width
   localparam int AW = 2 * WIDTH + 4;      // accumulator width
   localparam int CW = $clog2(N + 1);      // iteration counter width

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [AW-1:0]    acc;        // running partial sum
   logic [AW-1:0]    a_sh;       // A_ext sign-extended, pre-shifted by 2k
   logic [EW:0]      b_sh;       // {B_ext, 1'b0}; bits [2:0] are the triplet
   logic [CW-1:0]    cnt;
   logic             high_q;
   logic             done_q;
   logic [WIDTH-1:0] product_q;

   logic [EW-1:0]    a_ext;
   logic [EW-1:0]    b_ext;
   logic [AW-1:0]    pp;
   logic [AW-1:0]    acc_next;
   logic             last_iter;

   // Two extra bits make an unsigned WIDTH-bit value representable as a
   // positive two's-complement number, so one signed datapath covers all
   // four signedness combinations.
   always_comb begin
      a_ext = bus.signed_a_i ? {{2{bus.multiplicand_i[WIDTH-1]}}, bus.multiplicand_i}
                             : {2'b00, bus.multiplicand_i};
      b_ext = bus.signed_b_i ? {{2{bus.multiplier_i[WIDTH-1]}}, bus.multiplier_i}
                             : {2'b00, bus.multiplier_i};
   end

   // Radix-4 recoding of {b[2k+1], b[2k], b[2k-1]} into {-2..+2} * A.
   // a_sh already carries the 2k weight of the current digit.
   always_comb begin
      pp = '0;
      case (b_sh[2:0])
         3'b001, 3'b010: pp = a_sh;
         3'b011:         pp = a_sh << 1;
         3'b100:         pp = -(a_sh << 1);
         3'b101, 3'b110: pp = -a_sh;
         default:        pp = '0;
      endcase
      acc_next  = acc + pp;
      last_iter = (cnt == CW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         state     <= IDLE;
         acc       <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         cnt       <= '0;
         high_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush_i) begin
            // Drop the partial result; product_q keeps the last good value.
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start_i) begin
                     a_sh   <= {{(AW-EW){a_ext[EW-1]}}, a_ext};
                     b_sh   <= {b_ext, 1'b0};
                     high_q <= bus.high_i;
                     acc    <= '0;
                     cnt    <= '0;
                     state  <= RUN;
                  end
               end
               RUN: begin
                  acc  <= acc_next;
                  a_sh <= a_sh << 2;
                  // Zero fill is harmless: every bit of B_ext is consumed
                  // before any shifted-in bit reaches the triplet window.
                  b_sh <= b_sh >> 2;
                  cnt  <= cnt + CW'(1);
                  if (last_iter) begin
                     state     <= IDLE;
                     done_q    <= 1'b1;
                     product_q <= high_q ? acc_next[2*WIDTH-1:WIDTH]
                                         : acc_next[WIDTH-1:0];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy_o    = (state == RUN);
   assign bus.done_o    = done_q;
   assign bus.product_o = product_q;
   assign dbg_state     = (state == RUN);

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic state64;
   logic state8;

   int n_checks = 0;
   int n_errors = 0;

   booth_mul_seq_if #(.WIDTH(64)) bus64 ();
   booth_mul_seq_if #(.WIDTH(8))  bus8 ();

   booth_mul_seq #(.WIDTH(64)) u_dut64 (
      .clk       (clk),
      .reset_i   (reset_i),
      .bus       (bus64),
      .dbg_state (state64)
   );

   booth_mul_seq #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .reset_i   (reset_i),
      .bus       (bus8),
      .dbg_state (state8)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- WIDTH=64 driver tasks ----------------
   // Called so that the next posedge is the accept edge; returns at #1 in
   // cycle T+1 with inputs scrambled to prove they are sampled only on accept.
   task automatic issue64(input logic [63:0] a, input logic [63:0] b,
                          input logic sa, input logic sb, input logic hi);
      bus64.multiplicand_i = a;
      bus64.multiplier_i   = b;
      bus64.signed_a_i     = sa;
      bus64.signed_b_i     = sb;
      bus64.high_i         = hi;
      bus64.start_i        = 1'b1;
      @(posedge clk); #1;
      bus64.start_i        = 1'b0;
      bus64.multiplicand_i = ~a;
      bus64.multiplier_i   = ~b ^ 64'h5;
      bus64.signed_a_i     = ~sa;
      bus64.signed_b_i     = ~sb;
      bus64.high_i         = ~hi;
   endtask

   // lat counts cycles after the accept cycle T; done is due at T+34.
   task automatic wait_done64(input string tag, input logic [63:0] exp, input bit hold);
      int lat = 1;
      int busy_cnt = 0;
      bit seen = 0;
      for (int i = 0; i < 100; i++) begin
         if (bus64.done_o) begin
            seen = 1;
            break;
         end
         if (bus64.busy_o) busy_cnt++;
         if (hold) begin
            bus64.start_i        = (lat < 30);
            bus64.multiplicand_i = 64'h1234 + 64'(lat);
            bus64.multiplier_i   = 64'h10;
         end
         @(posedge clk); #1;
         lat++;
      end
      bus64.start_i = 1'b0;
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'd34);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
      check({tag, "_busy_at_done"}, 64'(bus64.busy_o), 64'd0);
      check({tag, "_product"}, bus64.product_o, exp);
   endtask

   task automatic mul64(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic sa, input logic sb, input logic hi, input logic [63:0] exp);
      @(negedge clk);
      issue64(a, b, sa, sb, hi);
      wait_done64(tag, exp, 1'b0);
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, 64'(bus64.done_o), 64'd0);
   endtask

   // ---------------- WIDTH=8 driver task ----------------
   task automatic mul8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sa, input logic sb, input logic hi, input logic [7:0] exp);
      int lat = 1;
      bit seen = 0;
      @(negedge clk);
      bus8.multiplicand_i = a;
      bus8.multiplier_i   = b;
      bus8.signed_a_i     = sa;
      bus8.signed_b_i     = sb;
      bus8.high_i         = hi;
      bus8.start_i        = 1'b1;
      @(posedge clk); #1;
      bus8.start_i        = 1'b0;
      bus8.multiplicand_i = 8'h00;
      bus8.multiplier_i   = 8'h00;
      for (int i = 0; i < 30; i++) begin
         if (bus8.done_o) begin
            seen = 1;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      check({tag, "_latency"}, 64'(lat), 64'd6);
      check({tag, "_product"}, 64'(bus8.product_o), 64'(exp));
   endtask

   // WIDTH=8 vectors covering all four signedness pairs, both halves.
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       sa;
      logic       sb;
      logic [7:0] hi_exp;
      logic [7:0] lo_exp;
   } vec8_t;

   vec8_t vec8 [8];

   initial begin
      vec8[0] = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 8'h01};  // 255*255 = 0xFE01
      vec8[1] = '{8'h80, 8'h80, 1'b1, 1'b1, 8'h40, 8'h00};  // -128*-128 = 0x4000
      vec8[2] = '{8'h80, 8'hFF, 1'b1, 1'b0, 8'h80, 8'h80};  // -128*255 = 0x8080
      vec8[3] = '{8'hFF, 8'h80, 1'b0, 1'b1, 8'h80, 8'h80};  // 255*-128 = 0x8080
      vec8[4] = '{8'h7F, 8'h81, 1'b1, 1'b1, 8'hC0, 8'hFF};  // 127*-127 = 0xC0FF
      vec8[5] = '{8'h7F, 8'h81, 1'b0, 1'b0, 8'h3F, 8'hFF};  // 127*129 = 0x3FFF
      vec8[6] = '{8'hFD, 8'h07, 1'b1, 1'b0, 8'hFF, 8'hEB};  // -3*7 = 0xFFEB
      vec8[7] = '{8'h0A, 8'hF6, 1'b0, 1'b1, 8'hFF, 8'h9C};  // 10*-10 = 0xFF9C
   end

   // ---------------- main sequence ----------------
   initial begin
      int ndone;
      bus64.start_i = 1'b0;
      bus64.flush_i = 1'b0;
      bus64.multiplicand_i = '0;
      bus64.multiplier_i = '0;
      bus64.signed_a_i = 1'b0;
      bus64.signed_b_i = 1'b0;
      bus64.high_i = 1'b0;
      bus8.start_i = 1'b0;
      bus8.flush_i = 1'b0;
      bus8.multiplicand_i = '0;
      bus8.multiplier_i = '0;
      bus8.signed_a_i = 1'b0;
      bus8.signed_b_i = 1'b0;
      bus8.high_i = 1'b0;

      reset_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus64.busy_o), 64'd0);
      check("rst_done", 64'(bus64.done_o), 64'd0);
      check("rst_product", bus64.product_o, 64'd0);
      check("rst_state", 64'(state64), 64'd0);
      check("rst_product8", 64'(bus8.product_o), 64'd0);
      @(negedge clk);
      reset_i = 1'b0;

      // Directed WIDTH=64 products.
      mul64("s_m3x7_lo", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
      mul64("u_max_hi", '1, '1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      mul64("u_max_lo", '1, '1, 1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
      mul64("s_min_hi", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
      mul64("s_min_lo", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0);
      mul64("su_hi", '1, '1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      mul64("su_lo", '1, '1, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
      mul64("us_hi", '1, '1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      mul64("ss_m1_hi", '1, '1, 1'b1, 1'b1, 1'b1, 64'h0);
      mul64("u_2p32_hi", 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b0, 1'b1, 64'h1);
      mul64("s_big_lo", 64'd123456789, 64'hFFFF_FFFF_FFFF_FC18, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFE3_4166_E5F8);

      // start held high with new operands during RUN is ignored; then a
      // start in the done cycle is accepted back-to-back.
      @(negedge clk);
      issue64(64'd5, 64'd6, 1'b0, 1'b0, 1'b0);
      wait_done64("hold_start", 64'd30, 1'b1);
      issue64(64'd9, 64'd9, 1'b0, 1'b0, 1'b0);
      wait_done64("b2b_second", 64'd81, 1'b0);

      // Flush at T+10: idle at T+11, no done, product keeps 81.
      @(negedge clk);
      issue64(64'd2, 64'd3, 1'b0, 1'b0, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus64.flush_i = 1'b1;
      @(posedge clk); #1;
      bus64.flush_i = 1'b0;
      check("flush_busy", 64'(bus64.busy_o), 64'd0);
      check("flush_state", 64'(state64), 64'd0);
      check("flush_done", 64'(bus64.done_o), 64'd0);
      check("flush_product", bus64.product_o, 64'd81);
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus64.done_o) ndone++;
      end
      check("flush_no_done", 64'(ndone), 64'd0);

      // Flush in the final RUN cycle (counter = N-1) still wins.
      @(negedge clk);
      issue64(64'd4, 64'd4, 1'b0, 1'b0, 1'b0);
      repeat (32) begin
         @(posedge clk); #1;
      end
      check("late_flush_busy_before", 64'(bus64.busy_o), 64'd1);
      bus64.flush_i = 1'b1;
      @(posedge clk); #1;
      bus64.flush_i = 1'b0;
      check("late_flush_done", 64'(bus64.done_o), 64'd0);
      check("late_flush_busy", 64'(bus64.busy_o), 64'd0);
      check("late_flush_product", bus64.product_o, 64'd81);

      // flush_i beats start_i in IDLE.
      @(negedge clk);
      bus64.start_i = 1'b1;
      bus64.flush_i = 1'b1;
      @(posedge clk); #1;
      bus64.start_i = 1'b0;
      bus64.flush_i = 1'b0;
      check("flush_vs_start_busy", 64'(bus64.busy_o), 64'd0);

      // Reset mid-RUN clears everything, including product_o.
      @(negedge clk);
      issue64(64'd7, 64'd7, 1'b0, 1'b0, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      check("midrst_busy", 64'(bus64.busy_o), 64'd0);
      check("midrst_done", 64'(bus64.done_o), 64'd0);
      check("midrst_product", bus64.product_o, 64'd0);
      check("midrst_state", 64'(state64), 64'd0);

      // Recovery after reset.
      mul64("post_rst", 64'd7, 64'd7, 1'b0, 1'b0, 1'b0, 64'd49);

      // WIDTH=8 sweep over all mode pairs, both halves.
      for (int i = 0; i < 8; i++) begin
         mul8($sformatf("w8_v%0d_hi", i), vec8[i].a, vec8[i].b, vec8[i].sa, vec8[i].sb, 1'b1, vec8[i].hi_exp);
         mul8($sformatf("w8_v%0d_lo", i), vec8[i].a, vec8[i].b, vec8[i].sa, vec8[i].sb, 1'b0, vec8[i].lo_exp);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   // Hard stop in case a wait above is ever left unbounded.
   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Parametrised multi-cycle radix-4 Booth multiplier for the pipeline's execute-stage multiply unit. Handles any even operand width, signed/unsigned operands independently (MUL/MULH/MULHSU/MULHU), and high/low product half select. Uses a start/busy/done handshake plus a flush input so the pipeline can kill an in-flight multiply on redirect.

## Interface
- WIDTH, 64, operand and result width; even, >= 4
- clk  input  1  clock, all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- flush_i  input  1  abort in-flight operation; no done_o generated
- start_i  input  1  request; accepted only when busy_o = 0
- multiplicand_i  input  WIDTH  operand A, sampled on accept
- multiplier_i  input  WIDTH  operand B (Booth-scanned), sampled on accept
- signed_a_i  input  1  1: A is two's complement; 0: unsigned
- signed_b_i  input  1  1: B is two's complement; 0: unsigned
- high_i  input  1  1: return product[2*WIDTH-1:WIDTH]; 0: product[WIDTH-1:0]
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse, product_o updated this cycle
- product_o  output  WIDTH  selected half of the last completed product

## Operation
- Operands extended to WIDTH+2 bits: sign-extend if signed_x_i, zero-extend otherwise. Accumulator is 2*WIDTH+4 bits; final result taken from bits [2*WIDTH-1:0] of the exact 2's-complement product.
- Iterations N = WIDTH/2 + 1 (33 for WIDTH=64). Iteration k (0..N-1) recodes triplet {B_ext[2k+1], B_ext[2k], B_ext[2k-1]} (B_ext[-1]=0) to digit in {-2,-1,0,+1,+2}; adds digit*A_ext << 2k to accumulator.
- States: IDLE, RUN.
  - IDLE: start_i=1 and flush_i=0 -> latch A_ext, B_ext, high_i; clear accumulator and counter; -> RUN.
  - RUN: one iteration per cycle; counter increments; after iteration N-1 -> IDLE, write selected half to product_o, assert done_o.
  - flush_i=1 in any state -> IDLE next cycle, accumulator discarded, product_o and done_o unchanged/0. flush_i has priority over start_i.
- start_i while busy_o=1 ignored (no queueing). Operand inputs ignored except on the accept cycle.
- product_o holds its value until the next completed operation; flushed operations never modify it.
- Mode and high_i captured at accept; changes during RUN have no effect.

## Timing
- Reset (reset_i=1 at edge): state IDLE, busy_o=0, done_o=0, product_o=0, counter and accumulator 0. Reset mid-RUN aborts identically to flush.
- Accept at edge ending cycle T: busy_o=1 cycles T+1..T+N; done_o=1 and product_o valid in cycle T+N+1; busy_o=0 in T+N+1.
- Latency start-to-done: N+1 cycles (34 for WIDTH=64). Throughput: one result per N+1 cycles.
- Back-to-back: start_i high in the done_o cycle is accepted (busy_o=0 there); next done_o at T+2N+2.
- done_o never high two consecutive cycles; never high with busy_o.
- flush_i in the final RUN cycle (counter = N-1) wins: no done_o, product_o unchanged.

## Test plan
- WIDTH=64, signed both, A=-3, B=7, high_i=0 -> product_o=0xFFFF_FFFF_FFFF_FFEB, done_o exactly 34 cycles after accept, busy_o high 33 cycles.
- Unsigned both, A=B=0xFFFF_FFFF_FFFF_FFFF: high_i=1 -> 0xFFFF_FFFF_FFFF_FFFE; high_i=0 -> 0x0000_0000_0000_0001.
- Signed both, A=B=0x8000_0000_0000_0000, high_i=1 -> 0x4000_0000_0000_0000; high_i=0 -> 0.
- MULHSU: signed_a_i=1 A=-1, signed_b_i=0 B=0xFFFF_FFFF_FFFF_FFFF, high_i=1 -> 0xFFFF_FFFF_FFFF_FFFF; low -> 0x1.
- Handshake: start_i held high during RUN with new operands -> ignored, result matches first operands; start in done cycle -> second done 34 cycles later.
- Flush/reset: flush_i at cycle T+10 -> busy_o=0 at T+11, no done_o, product_o keeps prior value; reset_i mid-RUN -> all outputs 0 next cycle; random signed/unsigned sweep at WIDTH=8 vs. reference model, all 4 mode pairs.
